// File: rtl/bram_port_arbiter.sv
// Two-requester (CPU, DMA) arbiter for BRAM port A with req/ack handshakes and registered outputs.
// Define BRAM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU has fixed priority.
module bram_port_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int MEM_SIZE = 512
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_ack_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] MemSizeU = 32'(MEM_SIZE);

  state_t            state_q, state_d;
  logic              grantDma_q, grantDma_d;
  logic              isWrite_q, isWrite_d;
  logic              inRange_q, inRange_d;
  logic              memEn_q, memEn_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memDin_q, memDin_d;
  logic              cpuAck_q, cpuAck_d;
  logic              dmaAck_q, dmaAck_d;
  logic [DATA_W-1:0] cpuRdata_q, cpuRdata_d;
  logic [DATA_W-1:0] dmaRdata_q, dmaRdata_d;

  logic              pickDma;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic              selInRange;
  logic [DATA_W-1:0] rdVal;

`ifdef BRAM_ARB_RR_EN
  logic lastDma_q, lastDma_d;

  // On a tie the requester that was not granted last time wins.
  assign pickDma = dma_req_i & (~cpu_req_i | ~lastDma_q);
`else
  assign pickDma = dma_req_i & ~cpu_req_i;
`endif

  assign selWe      = pickDma ? dma_we_i    : cpu_we_i;
  assign selAddr    = pickDma ? dma_addr_i  : cpu_addr_i;
  assign selData    = pickDma ? dma_wdata_i : cpu_wdata_i;
  assign selInRange = (32'(selAddr) < MemSizeU);
  // Out-of-range reads return all ones instead of whatever the BRAM drives.
  assign rdVal      = inRange_q ? mem_dout_i : '1;

  always_comb begin
    state_d    = state_q;
    grantDma_d = grantDma_q;
    isWrite_d  = isWrite_q;
    inRange_d  = inRange_q;
    memEn_d    = memEn_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memDin_d   = memDin_q;
    cpuAck_d   = 1'b0;
    dmaAck_d   = 1'b0;
    cpuRdata_d = cpuRdata_q;
    dmaRdata_d = dmaRdata_q;
`ifdef BRAM_ARB_RR_EN
    lastDma_d  = lastDma_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_req_i || dma_req_i) begin
          grantDma_d = pickDma;
          isWrite_d  = selWe;
          inRange_d  = selInRange;
          memEn_d    = 1'b1;
          memWe_d    = selWe & selInRange;
          memAddr_d  = selAddr;
          memDin_d   = selData;
`ifdef BRAM_ARB_RR_EN
          lastDma_d  = pickDma;
`endif
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        memEn_d = 1'b0;
        memWe_d = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        // The BRAM output register holds the read data during this cycle.
        if (grantDma_q) begin
          dmaAck_d = 1'b1;
          if (!isWrite_q) dmaRdata_d = rdVal;
        end else begin
          cpuAck_d = 1'b1;
          if (!isWrite_q) cpuRdata_d = rdVal;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q    <= IDLE;
      grantDma_q <= 1'b0;
      isWrite_q  <= 1'b0;
      inRange_q  <= 1'b0;
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memDin_q   <= '0;
      cpuAck_q   <= 1'b0;
      dmaAck_q   <= 1'b0;
      cpuRdata_q <= '0;
      dmaRdata_q <= '0;
`ifdef BRAM_ARB_RR_EN
      lastDma_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      grantDma_q <= grantDma_d;
      isWrite_q  <= isWrite_d;
      inRange_q  <= inRange_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memDin_q   <= memDin_d;
      cpuAck_q   <= cpuAck_d;
      dmaAck_q   <= dmaAck_d;
      cpuRdata_q <= cpuRdata_d;
      dmaRdata_q <= dmaRdata_d;
`ifdef BRAM_ARB_RR_EN
      lastDma_q  <= lastDma_d;
`endif
    end
  end

  assign cpu_ack_o   = cpuAck_q;
  assign dma_ack_o   = dmaAck_q;
  assign cpu_rdata_o = cpuRdata_q;
  assign dma_rdata_o = dmaRdata_q;
  assign mem_en_o    = memEn_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_din_o   = memDin_q;

endmodule
